modulator_frame_ctrl: RTL and testbench
=======================================

# modulator_frame_ctrl

Frame sequencer for the digital symbol modulator. Accepts frame descriptors (modulation, length in symbols) and a byte stream, then serializes the bytes MSB-first into the modulator's bit interface. It drives enable, bit-valid and modulation select so that exactly bits-per-symbol bits land in each 8-cycle symbol window. It also guarantees that the modulation only changes while the modulator is drained.

## Interface
- LEN_W, 8, width of frame length field (symbols per frame)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_frm_vld  in  1  frame descriptor valid
- o_frm_rdy  out  1  descriptor accepted when i_frm_vld & o_frm_rdy
- i_frm_mod  in  2  0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM
- i_frm_len  in  LEN_W  symbols in frame; 0 allowed
- i_byte_vld  in  1  payload byte valid
- o_byte_rdy  out  1  byte accepted when i_byte_vld & o_byte_rdy
- i_byte  in  8  payload byte, bit 7 sent first
- i_out_vld  in  1  modulator output-valid, fed back for drain detection
- o_en  out  1  modulator enable
- o_data_vld  out  1  modulator bit strobe
- o_data  out  1  modulator serial bit
- o_mod  out  2  modulator mode select
- o_busy  out  1  high in any state other than IDLE
- o_frm_done  out  1  one-cycle pulse at frame end
- o_underrun  out  1  one-cycle pulse per bit sent with empty buffer

## Operation
- Bits per symbol (bps): mod 0→1, 1→2, 2→4, 3→6.
- FSM states: IDLE, PRIME, RUN, DONE.
  - IDLE: o_frm_rdy=1. On accept, latch mod into o_mod and len.
    - Load the remaining-bit counter rem = len*bps (width LEN_W+3).
    - Go to PRIME, or to DONE if len=0.
  - PRIME: o_byte_rdy per the buffer rule below. Go to RUN when i_out_vld=0 and the buffer holds at least min(8, rem) bits. Slot counter is cleared on entry to RUN.
  - RUN: o_en=1. The 3-bit slot counter increments every cycle and wraps 7→0.
    - In slots 0..bps-1: o_data_vld=1, o_data = buffer MSB, buffer shifts by 1, rem decrements.
    - Slots bps..7: o_data_vld=0, o_data=0.
    - RUN lasts exactly len*8 cycles, then goes to DONE.
  - DONE: o_frm_done=1 for 1 cycle. Bit buffer is flushed; residual bits of the last byte are discarded. Go to IDLE.
- Bit buffer: 16 bits with a 0..16 fill count. A byte append writes to the bits immediately behind the current contents.
  - o_byte_rdy = (PRIME|RUN) & fill≤8 & fill<rem.
  - A frame consumes exactly ceil(len*bps/8) bytes.
- Same-cycle byte accept and bit consume: fill ← fill+8−1, with ordering preserved.
- Underrun: a slot needing a bit while fill=0 sends o_data=0 with o_data_vld=1, pulses o_underrun and still decrements rem. Window timing is never stretched.
- o_mod changes only on descriptor accept. It is held across DONE/IDLE.

## Timing
- Reset (synchronous, i_rst_n=0 at a clock edge): state IDLE, buffer and counters cleared.
  - o_frm_rdy=0 during reset, 1 in the first cycle after release.
  - All other outputs are 0 (o_mod=0).
  - Reset mid-frame aborts the frame with no o_frm_done.
- Descriptor accepted at edge T → PRIME from T+1. o_frm_rdy is low from T+1 until IDLE is re-entered.
- With a byte ready and i_out_vld=0, the byte is accepted at T+1 and the first o_en cycle is T+2.
- o_en is a contiguous len*8-cycle pulse. o_frm_done is asserted in the cycle after the last o_en cycle. o_frm_rdy is high the cycle after that.
- len=0: o_frm_done in the cycle after acceptance; no o_en, no byte accepted.
- A new frame never enters RUN while i_out_vld=1, so the previous frame's last symbol drains under its own o_mod.
- All outputs are registered; no combinational input→output paths except o_byte_rdy and o_frm_rdy, which are state-derived.

## Test plan
- BPSK len=2, byte 0xA5 → o_en 16 cycles; o_data_vld in slot 0 of each window with bits 1 then 0; one byte accepted; o_frm_done one cycle after o_en falls.
- 64QAM len=4, bytes 0x12,0x34,0x56 → exactly 3 bytes accepted; per-window bit groups 000100, 100011, 010001, 010110; o_data_vld high in slots 0..5 only.
- 16QAM len=3, bytes 0xC3,0x9F, then frame 2 BPSK len=1 byte 0x80 → frame 1 sends 1100,0011,1001; bits 1111 are discarded; frame 2 sends 1.
- QPSK len=8, only byte 0xFF supplied, i_byte_vld then held low → o_en still 64 cycles; symbols 0..3 = 11; symbols 4..7 = 00 with 8 o_underrun pulses.
- Frame 2 presented during frame 1 with i_out_vld held high 8 cycles after frame 1's DONE → o_frm_rdy low until IDLE; after acceptance, PRIME holds until i_out_vld=0; o_mod changes only at acceptance.
- i_rst_n low in RUN slot 3 → the following cycle all outputs are 0, o_frm_rdy=0 until release; no o_frm_done. Separately, len=0 → o_frm_done one cycle after acceptance and no bytes consumed.

Source files
------------

// File: rtl/modulator_frame_ctrl_if.sv
// Signal bundle between the frame sequencer, its descriptor/byte sources and
// the symbol modulator. clk/rst stay as plain ports on the sequencer.
interface modulator_frame_ctrl_if #(
    parameter int LEN_W = 8
) ();
    logic             i_frm_vld;
    logic             o_frm_rdy;
    logic [1:0]       i_frm_mod;
    logic [LEN_W-1:0] i_frm_len;
    logic             i_byte_vld;
    logic             o_byte_rdy;
    logic [7:0]       i_byte;
    logic             i_out_vld;
    logic             o_en;
    logic             o_data_vld;
    logic             o_data;
    logic [1:0]       o_mod;
    logic             o_busy;
    logic             o_frm_done;
    logic             o_underrun;

    modport slave (
        input  i_frm_vld, i_frm_mod, i_frm_len, i_byte_vld, i_byte, i_out_vld,
        output o_frm_rdy, o_byte_rdy, o_en, o_data_vld, o_data, o_mod,
               o_busy, o_frm_done, o_underrun
    );

    modport master (
        output i_frm_vld, i_frm_mod, i_frm_len, i_byte_vld, i_byte, i_out_vld,
        input  o_frm_rdy, o_byte_rdy, o_en, o_data_vld, o_data, o_mod,
               o_busy, o_frm_done, o_underrun
    );
endinterface

// File: rtl/modulator_frame_ctrl.sv
// Frame sequencer: takes (modulation, length) descriptors and a byte stream,
// serializes bytes MSB-first so that exactly bits-per-symbol bits fall in
// each 8-cycle symbol window, and only switches modulation while drained.
module modulator_frame_ctrl #(
    parameter int LEN_W = 8
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    modulator_frame_ctrl_if.slave bus
);
    localparam int RW = LEN_W + 3;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] sym_q, sym_d;
    logic [2:0]       slot_q, slot_d;
    logic [15:0]      bits_q, bits_d;
    logic [4:0]       fill_q, fill_d;
    logic [1:0]       mod_q;

    logic             en_q, dvld_q, data_q, busy_q, done_q, under_q;

    logic             frm_rdy, frm_acc, byte_rdy, byte_acc, pop;
    logic [15:0]      merged;
    logic [4:0]       merged_fill;
    logic [RW-1:0]    need;
    logic [2:0]       bps;
    logic             out_bit, under;

    function automatic logic [2:0] bps_of(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    assign bps = bps_of(mod_q);

    assign bus.o_frm_rdy  = frm_rdy;
    assign bus.o_byte_rdy = byte_rdy;
    assign bus.o_en       = en_q;
    assign bus.o_data_vld = dvld_q;
    assign bus.o_data     = data_q;
    assign bus.o_mod      = mod_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_frm_done = done_q;
    assign bus.o_underrun = under_q;

    // Next state, handshakes and bit-buffer update (append then consume).
    always_comb begin
        state_d  = state_q;
        frm_rdy  = (state_q == IDLE) && i_rst_n;
        frm_acc  = bus.i_frm_vld && frm_rdy;
        byte_rdy = ((state_q == PRIME) || (state_q == RUN)) &&
                   (fill_q <= 5'd8) && (RW'(fill_q) < rem_q);
        byte_acc = bus.i_byte_vld && byte_rdy;

        // A newly accepted byte lands directly behind the bits still queued.
        merged      = bits_q | (byte_acc ? ({bus.i_byte, 8'h00} >> fill_q) : '0);
        merged_fill = fill_q + (byte_acc ? 5'd8 : 5'd0);
        need        = (rem_q < RW'(8)) ? rem_q : RW'(8);

        len_d = len_q;
        case (state_q)
            IDLE: begin
                if (frm_acc) begin
                    len_d   = bus.i_frm_len;
                    state_d = (bus.i_frm_len == '0) ? DONE : PRIME;
                end
            end
            PRIME: begin
                if (!bus.i_out_vld && (RW'(merged_fill) >= need)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((slot_q == 3'd7) && (sym_q == len_q - LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        slot_d = (state_q == RUN) ? slot_q + 3'd1 : '0;
        if (state_q == RUN) begin
            sym_d = (slot_q == 3'd7) ? sym_q + LEN_W'(1) : sym_q;
        end else begin
            sym_d = '0;
        end

        // Bits are popped on the edge that opens the slot they are sent in.
        pop     = (state_d == RUN) && (slot_d < bps);
        out_bit = pop && (merged_fill != '0) && merged[15];
        under   = pop && (merged_fill == '0);

        bits_d = merged;
        fill_d = merged_fill;
        rem_d  = rem_q;
        if (pop) begin
            bits_d = merged << 1;
            fill_d = (merged_fill == '0) ? '0 : merged_fill - 5'd1;
            rem_d  = (rem_q == '0) ? '0 : rem_q - RW'(1);
        end
        if (frm_acc) begin
            rem_d = RW'(bus.i_frm_len) * RW'(bps_of(bus.i_frm_mod));
        end
        if (state_d == DONE) begin
            bits_d = '0;
            fill_d = '0;
            rem_d  = '0;
        end
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            len_q   <= '0;
            sym_q   <= '0;
            slot_q  <= '0;
            bits_q  <= '0;
            fill_q  <= '0;
            mod_q   <= '0;
            en_q    <= 1'b0;
            dvld_q  <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            sym_q   <= sym_d;
            slot_q  <= slot_d;
            bits_q  <= bits_d;
            fill_q  <= fill_d;
            if (frm_acc) begin
                mod_q <= bus.i_frm_mod;
            end
            en_q    <= (state_d == RUN);
            dvld_q  <= pop;
            data_q  <= out_bit;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            under_q <= under;
        end
    end
endmodule

// File: tb/tb_modulator_frame_ctrl.sv
// Directed bench for modulator_frame_ctrl with an expected-bit scoreboard.
module tb_modulator_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    modulator_frame_ctrl_if #(.LEN_W(8)) bus ();

    modulator_frame_ctrl #(.LEN_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic b;
        logic ur;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] feed[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int en_total = 0;
    int en_run = 0;
    int ur_total = 0;
    int bytes_taken = 0;
    int last_en_cycle = -10;
    int done_total = 0;
    int exp_bps = 1;
    int slot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: window slot tracking and scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_en) begin
            slot = en_run % 8;
            en_run++;
            en_total++;
            last_en_cycle = cyc;
            check("data_vld", bus.o_data_vld, (slot < exp_bps) ? 1 : 0);
            if (slot < exp_bps) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", bus.o_data_vld, 0);
                end else begin
                    e = sb.pop_front();
                    check("data_bit", bus.o_data, e.b);
                    check("underrun", bus.o_underrun, e.ur);
                end
            end else begin
                check("gap_slot", {bus.o_data, bus.o_underrun}, 0);
            end
        end else begin
            en_run = 0;
            check("quiet", {bus.o_data_vld, bus.o_data, bus.o_underrun}, 0);
        end
        if (bus.o_underrun) ur_total++;
        if (bus.o_frm_done) done_total++;
    end

    task automatic feeder();
        logic acc;
        forever begin
            @(negedge clk);
            acc = bus.i_byte_vld && bus.o_byte_rdy;
            @(posedge clk);
            #1;
            if (acc && feed.size() > 0) begin
                void'(feed.pop_front());
                bytes_taken++;
            end
            if (feed.size() > 0) begin
                bus.i_byte_vld = 1'b1;
                bus.i_byte     = feed[0];
            end else begin
                bus.i_byte_vld = 1'b0;
                bus.i_byte     = 8'h00;
            end
        end
    endtask

    task automatic queue_frame(input int bps, input int len, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2, input int nb);
        logic [7:0] bs[3];
        exp_t e;
        bs = '{b0, b1, b2};
        for (int i = 0; i < nb; i++) feed.push_back(bs[i]);
        for (int i = 0; i < len * bps; i++) begin
            if (i / 8 < nb) begin
                e.b  = bs[i / 8][7 - (i % 8)];
                e.ur = 1'b0;
            end else begin
                e.b  = 1'b0;
                e.ur = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [1:0] m, input int len);
        bit ok;
        @(posedge clk);
        #1;
        bus.i_frm_vld = 1'b1;
        bus.i_frm_mod = m;
        bus.i_frm_len = len[7:0];
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.o_frm_rdy) ok = 1;
        end
        if (!ok) check("frm_rdy_timeout", bus.o_frm_rdy, 1);
        @(posedge clk);
        #1;
        bus.i_frm_vld = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_frm_done) seen = 1;
        end
        if (!seen) check("done_timeout", bus.o_frm_done, 1);
    endtask

    // Full frame with data available and modulator drained.
    task automatic run_frame(input logic [1:0] m, input int len, input int bps,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nb, input int nbytes, input int nur);
        int en0, by0, ur0;
        exp_bps = bps;
        en0 = en_total;
        by0 = bytes_taken;
        ur0 = ur_total;
        queue_frame(bps, len, b0, b1, b2, nb);
        send_frame(m, len);
        @(negedge clk);
        check("mod_at_accept", bus.o_mod, m);
        check("rdy_low_prime", bus.o_frm_rdy, 0);
        check("busy_prime", bus.o_busy, 1);
        check("en_prime", bus.o_en, 0);
        @(negedge clk);
        check("first_en", bus.o_en, 1);
        wait_done();
        check("en_cycles", en_total - en0, len * 8);
        check("bytes_taken", bytes_taken - by0, nbytes);
        check("underrun_cnt", ur_total - ur0, nur);
        check("sb_left", sb.size(), 0);
        check("done_after_en", cyc - last_en_cycle, 1);
        @(negedge clk);
        check("done_pulse", bus.o_frm_done, 0);
        check("rdy_after_done", bus.o_frm_rdy, 1);
        check("busy_idle", bus.o_busy, 0);
    endtask

    initial begin
        int en0, by0, d0;
        bus.i_frm_vld  = 1'b0;
        bus.i_frm_mod  = 2'd0;
        bus.i_frm_len  = 8'd0;
        bus.i_byte_vld = 1'b0;
        bus.i_byte     = 8'h00;
        bus.i_out_vld  = 1'b0;
        fork
            feeder();
        join_none

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frm_rdy", bus.o_frm_rdy, 0);
        check("rst_outs", {bus.o_en, bus.o_busy, bus.o_frm_done, bus.o_byte_rdy, bus.o_mod}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", bus.o_frm_rdy, 1);

        // BPSK len 2, 0xA5 -> bits 1,0
        run_frame(2'd0, 2, 1, 8'hA5, 8'h00, 8'h00, 1, 1, 0);
        // 64QAM len 4, three bytes
        run_frame(2'd3, 4, 6, 8'h12, 8'h34, 8'h56, 3, 3, 0);
        // 16QAM len 3: residual 1111 of 0x9F discarded
        run_frame(2'd2, 3, 4, 8'hC3, 8'h9F, 8'h00, 2, 2, 0);
        run_frame(2'd0, 1, 1, 8'h80, 8'h00, 8'h00, 1, 1, 0);
        // QPSK len 8 with a single byte -> 8 underruns
        run_frame(2'd1, 8, 2, 8'hFF, 8'h00, 8'h00, 1, 1, 8);

        // descriptor during a frame, modulator still draining afterwards
        exp_bps = 2;
        en0 = en_total;
        by0 = bytes_taken;
        queue_frame(2, 1, 8'h9C, 8'h00, 8'h00, 1);
        queue_frame(6, 1, 8'h3C, 8'h00, 8'h00, 1);
        send_frame(2'd1, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.i_frm_vld = 1'b1;
        bus.i_frm_mod = 2'd3;
        bus.i_frm_len = 8'd1;
        bus.i_out_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("rdy_while_busy", bus.o_frm_rdy, 0);
            check("mod_hold_f1", bus.o_mod, 1);
            if (bus.o_frm_done) break;
        end
        check("f1_done_seen", bus.o_frm_done, 1);
        exp_bps = 6;
        @(negedge clk);
        check("rdy_idle", bus.o_frm_rdy, 1);
        check("mod_idle", bus.o_mod, 1);
        @(posedge clk);
        #1;
        bus.i_frm_vld = 1'b0;
        repeat (7) begin
            @(negedge clk);
            check("prime_hold_en", bus.o_en, 0);
            check("prime_mod", bus.o_mod, 3);
            check("prime_busy", bus.o_busy, 1);
        end
        @(posedge clk);
        #1;
        bus.i_out_vld = 1'b0;
        @(negedge clk);
        check("prime_last", bus.o_en, 0);
        @(negedge clk);
        check("run_after_drain", bus.o_en, 1);
        wait_done();
        check("f2_en_cycles", en_total - en0, 16);
        check("f2_bytes", bytes_taken - by0, 2);
        check("f2_sb_left", sb.size(), 0);
        @(negedge clk);

        // len 0: done right after accept, byte left untouched
        by0 = bytes_taken;
        en0 = en_total;
        feed.push_back(8'h80);
        send_frame(2'd2, 0);
        @(negedge clk);
        check("len0_done", bus.o_frm_done, 1);
        check("len0_mod", bus.o_mod, 2);
        @(negedge clk);
        check("len0_done_pulse", bus.o_frm_done, 0);
        check("len0_rdy", bus.o_frm_rdy, 1);
        check("len0_bytes", bytes_taken - by0, 0);
        check("len0_en", en_total - en0, 0);
        feed.delete();

        // reset in RUN slot 3
        exp_bps = 1;
        queue_frame(1, 2, 8'hA5, 8'h00, 8'h00, 1);
        send_frame(2'd0, 2);
        for (int i = 0; i < 50 && !bus.o_en; i++) @(negedge clk);
        check("rst_test_en", bus.o_en, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        d0 = done_total;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outs", {bus.o_en, bus.o_data_vld, bus.o_data, bus.o_busy,
                              bus.o_frm_done, bus.o_underrun, bus.o_mod, bus.o_byte_rdy}, 0);
        check("midrst_rdy", bus.o_frm_rdy, 0);
        sb.delete();
        feed.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_midrst", bus.o_frm_rdy, 1);
        check("no_done_on_rst", done_total - d0, 0);

        // recovery
        run_frame(2'd0, 1, 1, 8'h80, 8'h00, 8'h00, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
